// File: rtl/otter_pkg.sv
// Shared opcode constants, NOP encoding and EX-stage control bundle for the OTTER pipeline.
package otter_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [3:0] alu_fun;
    logic       alu_srca;
    logic [1:0] alu_srcb;
    logic [1:0] rf_wr_sel;
    logic       reg_write;
    logic       mem_we2;
    logic       mem_rden2;
    logic       branch;
  } ex_ctrl_t;

  function automatic logic uses_rs1(input logic [6:0] op);
    return (op == OP_JALR) || (op == OP_LOAD) || (op == OP_STORE) ||
           (op == OP_IMM) || (op == OP_REG) || (op == OP_BRANCH);
  endfunction

  function automatic logic uses_rs2(input logic [6:0] op);
    return (op == OP_STORE) || (op == OP_REG) || (op == OP_BRANCH);
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detection between the instruction in decode and a load sitting in EX.
module hazard_detect
  import otter_pkg::*;
(
  input  logic [31:0] i_id_ir,
  input  logic        i_id_valid,
  input  logic [4:0]  i_ex_rd,
  input  logic        i_ex_mem_rden2,
  input  logic        i_ex_valid,
  output logic        o_haz
);

  logic [6:0] w_op;
  logic       w_rs1_hit;
  logic       w_rs2_hit;

  always_comb begin
    w_op      = i_id_ir[6:0];
    w_rs1_hit = uses_rs1(w_op) && (i_id_ir[19:15] == i_ex_rd);
    w_rs2_hit = uses_rs2(w_op) && (i_id_ir[24:20] == i_ex_rd);
    o_haz     = i_ex_valid && i_ex_mem_rden2 && (i_ex_rd != 5'd0) && i_id_valid &&
                (w_rs1_hit || w_rs2_hit);
  end

endmodule

// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register with load-use bubble insertion, flush, hold and saturating counters.
module id_ex_pipe
  import otter_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_id_valid,
  input  logic [31:0]      i_id_pc,
  input  logic [31:0]      i_id_ir,
  input  logic [31:0]      i_id_rs1_data,
  input  logic [31:0]      i_id_rs2_data,
  input  logic [3:0]       i_alu_fun,
  input  logic             i_alu_srca,
  input  logic [1:0]       i_alu_srcb,
  input  logic [1:0]       i_rf_wr_sel,
  input  logic             i_reg_write,
  input  logic             i_mem_we2,
  input  logic             i_mem_rden2,
  input  logic             i_branch,
  input  logic             i_flush,
  input  logic             i_ex_hold,
  output logic             o_ex_valid,
  output logic [31:0]      o_ex_pc,
  output logic [31:0]      o_ex_ir,
  output logic [31:0]      o_ex_rs1_data,
  output logic [31:0]      o_ex_rs2_data,
  output logic [3:0]       o_ex_alu_fun,
  output logic             o_ex_alu_srca,
  output logic [1:0]       o_ex_alu_srcb,
  output logic [1:0]       o_ex_rf_wr_sel,
  output logic             o_ex_reg_write,
  output logic             o_ex_mem_we2,
  output logic             o_ex_mem_rden2,
  output logic             o_ex_branch,
  output logic [4:0]       o_ex_rd,
  output logic             o_stall_id,
  output logic [CNT_W-1:0] o_stall_cnt,
  output logic [CNT_W-1:0] o_flush_cnt
);

  logic             r_valid;
  logic [31:0]      r_pc;
  logic [31:0]      r_ir;
  logic [31:0]      r_rs1;
  logic [31:0]      r_rs2;
  ex_ctrl_t         r_ctrl;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  logic     w_haz;
  logic     w_no_wb;
  ex_ctrl_t w_ctrl_in;

  hazard_detect u_hazard_detect (
    .i_id_ir       (i_id_ir),
    .i_id_valid    (i_id_valid),
    .i_ex_rd       (r_ir[11:7]),
    .i_ex_mem_rden2(r_ctrl.mem_rden2),
    .i_ex_valid    (r_valid),
    .o_haz         (w_haz)
  );

  // Branches and stores never write the register file, whatever the decoder says.
  always_comb begin
    w_no_wb             = (i_id_ir[6:0] == OP_BRANCH) || (i_id_ir[6:0] == OP_STORE);
    w_ctrl_in.alu_fun   = i_alu_fun;
    w_ctrl_in.alu_srca  = i_alu_srca;
    w_ctrl_in.alu_srcb  = i_alu_srcb;
    w_ctrl_in.rf_wr_sel = i_rf_wr_sel;
    w_ctrl_in.reg_write = i_reg_write && i_id_valid && !w_no_wb;
    w_ctrl_in.mem_we2   = i_mem_we2 && i_id_valid;
    w_ctrl_in.mem_rden2 = i_mem_rden2 && i_id_valid;
    w_ctrl_in.branch    = i_branch && i_id_valid;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_valid     <= 1'b0;
      r_pc        <= '0;
      r_ir        <= NOP_INSTR;
      r_rs1       <= '0;
      r_rs2       <= '0;
      r_ctrl      <= '0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else if (i_ex_hold) begin
      r_valid <= r_valid;
    end else if (i_flush || w_haz) begin
      r_valid <= 1'b0;
      r_pc    <= '0;
      r_ir    <= NOP_INSTR;
      r_rs1   <= '0;
      r_rs2   <= '0;
      r_ctrl  <= '0;
      // A flush wins over a coincident hazard and is the only event counted.
      if (i_flush) begin
        if (r_flush_cnt != '1) r_flush_cnt <= r_flush_cnt + 1'b1;
      end else begin
        if (r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + 1'b1;
      end
    end else begin
      r_valid <= i_id_valid;
      r_pc    <= i_id_pc;
      r_ir    <= i_id_ir;
      r_rs1   <= i_id_rs1_data;
      r_rs2   <= i_id_rs2_data;
      r_ctrl  <= w_ctrl_in;
    end
  end

  always_comb begin
    o_ex_valid     = r_valid;
    o_ex_pc        = r_pc;
    o_ex_ir        = r_ir;
    o_ex_rs1_data  = r_rs1;
    o_ex_rs2_data  = r_rs2;
    o_ex_alu_fun   = r_ctrl.alu_fun;
    o_ex_alu_srca  = r_ctrl.alu_srca;
    o_ex_alu_srcb  = r_ctrl.alu_srcb;
    o_ex_rf_wr_sel = r_ctrl.rf_wr_sel;
    o_ex_reg_write = r_ctrl.reg_write;
    o_ex_mem_we2   = r_ctrl.mem_we2;
    o_ex_mem_rden2 = r_ctrl.mem_rden2;
    o_ex_branch    = r_ctrl.branch;
    o_ex_rd        = r_ir[11:7];
    o_stall_id     = i_ex_hold || (w_haz && !i_flush);
    o_stall_cnt    = r_stall_cnt;
    o_flush_cnt    = r_flush_cnt;
  end

endmodule
